rvc_asap_5pl_mem_dump: RTL and testbench
========================================

Name: rvc_asap_5pl_mem_dump

Overview:
- Synthesizable end-of-test data-memory dumper for the rvc_asap_5pl core.
- On the first ebreak (32'h00100073) seen in the decode-stage instruction, it halts the core and reads D_MEM word by word through a dedicated read port.
- It streams every word out as bytes over a valid/ready byte interface (UART TX or host link).
- It is the hardware counterpart of the bench's memory snapshot: same address range, same byte order.

Parameters:
- D_MEM_OFFSET, 'h1000, byte address of the first dumped word.
- D_MEM_WORDS, 1024, number of 32-bit words dumped (4 KB).
- EBREAK_OPC, 32'h00100073, trigger instruction encoding.

Ports:
- Clock  in  1  core clock.
- Rst  in  1  synchronous, active-high reset.
- InstructionQ101H  in  32  instruction in the decode stage.
- CoreHalt  out  1  stalls/freezes the core pipeline while dumping and after completion.
- DumpRdEn  out  1  D_MEM read request.
- DumpRdAddr  out  32  byte address, word aligned.
- DumpRdData  in  32  read data, valid exactly 1 cycle after DumpRdEn.
- TxValid  out  1  byte available.
- TxData  out  8  byte value.
- TxReady  in  1  sink accepts the byte when TxValid&&TxReady at a rising edge.
- DumpBusy  out  1  FSM not in IDLE and not in DONE.
- DumpDone  out  1  sticky completion flag.

Behaviour:
- Reset (sync, active-high, overrides everything): state=IDLE, word_cnt=0, byte_cnt=0.
  - All outputs 0 at the edge where Rst=1: CoreHalt, DumpRdEn, DumpRdAddr, TxValid, TxData, DumpBusy, DumpDone.
  - Reset mid-dump aborts; TxValid drops at that edge regardless of TxReady.
- IDLE: if InstructionQ101H==EBREAK_OPC, go to RD_REQ and set CoreHalt=1 from the next cycle.
- RD_REQ (1 cycle): DumpRdEn=1, DumpRdAddr=D_MEM_OFFSET+4*word_cnt. Next state RD_WAIT.
- RD_WAIT (1 cycle): DumpRdEn=0; DumpRdData is captured into a 32-bit shift register at the end of this cycle. Next state SEND, byte_cnt=0.
- SEND: TxValid=1.
  - TxData order: byte_cnt 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0] (MSB first, matches the snapshot print order).
  - Byte and shift-register contents are held stable while TxValid&&!TxReady (no change without handshake).
  - On handshake: byte_cnt++.
  - On the handshake of byte_cnt==3:
    - if word_cnt==D_MEM_WORDS-1 → DONE;
    - else word_cnt++ → RD_REQ.
  - No valid bubble between bytes of one word; 2 idle TX cycles (RD_REQ, RD_WAIT) between words.
- DONE: DumpDone=1, CoreHalt=1, TxValid=0. Held until Rst.
- Ebreak while not in IDLE is ignored. Ebreak in DONE is also ignored: exactly one dump per reset.
- CoreHalt is 1 in every state except IDLE.
- Throughput with TxReady tied 1: 6 cycles/word; DumpDone rises 6*D_MEM_WORDS cycles after the RD_REQ entry edge.
- word_cnt width: $clog2(D_MEM_WORDS), minimum 1. Address arithmetic is 32-bit with no wrap; the last address is D_MEM_OFFSET+4*(D_MEM_WORDS-1).

Decomposition:
- Shared package rvc_asap_pkg holds:
  - EBREAK opcode constant;
  - D_MEM_OFFSET/size constants (reuse existing D_MEM definitions);
  - typedef enum t_dump_state {DUMP_IDLE, DUMP_RD_REQ, DUMP_RD_WAIT, DUMP_SEND, DUMP_DONE}.
- One flat module; the byte serializer is small enough to stay inline. Flops use the existing RVC_MSFF/reset macros.
- D_MEM needs an extra read port (or a mux onto the existing port gated by CoreHalt). That change belongs to the mem wrap, not this block.

Test Plan:
- D_MEM_WORDS=4, words at 'h1000..'h100C = 32'h11223344, 32'hAABBCCDD, 0, 32'hFFFFFFFF; ebreak injected; TxReady=1 → bytes 11 22 33 44 AA BB CC DD 00 00 00 00 FF FF FF FF; DumpDone high 24 cycles after RD_REQ; CoreHalt high from the cycle after ebreak.
- Backpressure: TxReady random 30% duty → same 16-byte sequence; TxData never changes while TxValid&&!TxReady; no byte duplicated or lost.
- Read addressing: DumpRdAddr sequence is 'h1000, 'h1004, 'h1008, 'h100C; each value appears with DumpRdEn=1 for exactly one cycle.
- Second ebreak during SEND, and another after DONE → no restart; total byte count stays 16; DumpDone stays 1.
- Rst asserted during byte 2 of word 1 → next cycle all outputs 0, state IDLE; a new ebreak restarts from 'h1000 with byte 11.
- No ebreak for 1000 cycles → CoreHalt=0, TxValid=0, DumpRdEn=0 throughout.

Source files
------------

// File: rtl/rvc_asap_pkg.sv
// Shared constants and types for the rvc_asap_5pl core.
// Holds the D_MEM map, the ebreak encoding and the dump FSM states.
package rvc_asap_pkg;

    localparam logic [31:0] D_MEM_OFST      = 32'h0000_1000;
    localparam int          D_MEM_NUM_WORDS = 1024;
    localparam logic [31:0] EBREAK_OPCODE   = 32'h0010_0073;

    typedef enum logic [2:0] {
        DUMP_IDLE,
        DUMP_RD_REQ,
        DUMP_RD_WAIT,
        DUMP_SEND,
        DUMP_DONE
    } t_dump_state;

endpackage

// File: rtl/rvc_asap_5pl_mem_dump.sv
// End-of-test D_MEM dumper: halts the core on the first ebreak
// and streams every data word out MSB first over a byte handshake.
module rvc_asap_5pl_mem_dump
    import rvc_asap_pkg::*;
#(
    parameter logic [31:0] D_MEM_OFFSET = D_MEM_OFST,
    parameter int          D_MEM_WORDS  = D_MEM_NUM_WORDS,
    parameter logic [31:0] EBREAK_OPC   = EBREAK_OPCODE
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic [31:0] InstructionQ101H,
    output logic        CoreHalt,
    output logic        DumpRdEn,
    output logic [31:0] DumpRdAddr,
    input  logic [31:0] DumpRdData,
    output logic        TxValid,
    output logic [7:0]  TxData,
    input  logic        TxReady,
    output logic        DumpBusy,
    output logic        DumpDone
);

    localparam int WCW = (D_MEM_WORDS > 1) ? $clog2(D_MEM_WORDS) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(D_MEM_WORDS - 1);

    t_dump_state    state;
    t_dump_state    next_state;
    logic [WCW-1:0] word_cnt;
    logic [1:0]     byte_cnt;
    logic [31:0]    shreg;
    logic           tx_hs;
    logic           last_byte;

    assign tx_hs     = (state == DUMP_SEND) && TxReady;
    assign last_byte = (byte_cnt == 2'd3);

    always_comb begin
        next_state = state;
        unique case (state)
            DUMP_IDLE: begin
                if (InstructionQ101H == EBREAK_OPC)
                    next_state = DUMP_RD_REQ;
            end
            DUMP_RD_REQ:  next_state = DUMP_RD_WAIT;
            DUMP_RD_WAIT: next_state = DUMP_SEND;
            DUMP_SEND: begin
                if (tx_hs && last_byte)
                    next_state = (word_cnt == LAST_WORD) ?
                                 DUMP_DONE : DUMP_RD_REQ;
            end
            DUMP_DONE:    next_state = DUMP_DONE;
            default:      next_state = DUMP_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state    <= DUMP_IDLE;
            word_cnt <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
        end else begin
            state <= next_state;
            if (state == DUMP_RD_WAIT) begin
                shreg    <= DumpRdData;
                byte_cnt <= '0;
            end else if (tx_hs) begin
                // Shift so the outgoing byte is always shreg[31:24]
                shreg    <= {shreg[23:0], 8'h00};
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte && (word_cnt != LAST_WORD))
                    word_cnt <= word_cnt + WCW'(1);
            end
        end
    end

    assign CoreHalt   = (state != DUMP_IDLE);
    assign DumpRdEn   = (state == DUMP_RD_REQ);
    assign DumpRdAddr = DumpRdEn ?
                        D_MEM_OFFSET + (32'(word_cnt) << 2) : '0;
    assign TxValid    = (state == DUMP_SEND);
    assign TxData     = TxValid ? shreg[31:24] : '0;
    assign DumpBusy   = (state != DUMP_IDLE) && (state != DUMP_DONE);
    assign DumpDone   = (state == DUMP_DONE);

endmodule

// File: tb/tb_rvc_asap_5pl_mem_dump.sv
// Directed bench for the D_MEM dumper with a 4-word memory image.
// Inputs change on the falling edge; outputs are read there too.
module tb_rvc_asap_5pl_mem_dump;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        Clock = 1'b0;
    logic        Rst;
    logic [31:0] InstructionQ101H;
    logic        CoreHalt;
    logic        DumpRdEn;
    logic [31:0] DumpRdAddr;
    logic [31:0] DumpRdData;
    logic        TxValid;
    logic [7:0]  TxData;
    logic        TxReady;
    logic        DumpBusy;
    logic        DumpDone;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [4];
    logic [7:0]  exp_bytes [16];
    logic [31:0] exp_addr [4];
    logic [7:0]  got [$];
    logic [31:0] addrs [$];

    rvc_asap_5pl_mem_dump #(
        .D_MEM_OFFSET(32'h0000_1000),
        .D_MEM_WORDS (4),
        .EBREAK_OPC  (32'h0010_0073)
    ) dut (
        .Clock           (Clock),
        .Rst             (Rst),
        .InstructionQ101H(InstructionQ101H),
        .CoreHalt        (CoreHalt),
        .DumpRdEn        (DumpRdEn),
        .DumpRdAddr      (DumpRdAddr),
        .DumpRdData      (DumpRdData),
        .TxValid         (TxValid),
        .TxData          (TxData),
        .TxReady         (TxReady),
        .DumpBusy        (DumpBusy),
        .DumpDone        (DumpDone)
    );

    always #5 Clock = ~Clock;

    // D_MEM read port: data valid exactly one cycle after the request
    always @(posedge Clock)
        DumpRdData <= DumpRdEn ? mem[DumpRdAddr[3:2]] : 32'hDEAD_BEEF;

    task automatic do_reset();
        @(negedge Clock);
        Rst = 1'b1;
        InstructionQ101H = NOP;
        TxReady = 1'b0;
        repeat (2) @(negedge Clock);
        Rst = 1'b0;
        got.delete();
        addrs.delete();
    endtask

    task automatic fire_ebreak();
        InstructionQ101H = EBREAK;
        @(negedge Clock);
        InstructionQ101H = NOP;
    endtask

    task automatic sample(input bit rdy);
        TxReady = rdy;
        if (DumpRdEn)
            addrs.push_back(DumpRdAddr);
        if (TxValid && rdy)
            got.push_back(TxData);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        InstructionQ101H = NOP;
        TxReady = 1'b1;
        @(negedge Clock);
        checks++;
        if (CoreHalt !== 1'b0) begin
            failures++;
            $display("FAIL reset_CoreHalt got=%b exp=0", CoreHalt);
        end
        checks++;
        if (DumpRdEn !== 1'b0 || DumpRdAddr !== 32'h0) begin
            failures++;
            $display("FAIL reset_rd got en=%b addr=%h exp 0/0",
                     DumpRdEn, DumpRdAddr);
        end
        checks++;
        if (TxValid !== 1'b0 || TxData !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx got v=%b d=%h exp 0/00",
                     TxValid, TxData);
        end
        checks++;
        if (DumpBusy !== 1'b0 || DumpDone !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%b done=%b exp 0/0",
                     DumpBusy, DumpDone);
        end
    endtask

    task automatic test_stream();
        int done_at = -1;
        int halt_bad = 0;
        do_reset();
        checks++;
        if (CoreHalt !== 1'b0) begin
            failures++;
            $display("FAIL pre_ebreak_halt got=%b exp=0", CoreHalt);
        end
        fire_ebreak();
        checks++;
        if (DumpRdEn !== 1'b1 || DumpBusy !== 1'b1) begin
            failures++;
            $display("FAIL first_rd_req got en=%b busy=%b exp 1/1",
                     DumpRdEn, DumpBusy);
        end
        for (int n = 0; n < 30; n++) begin
            sample(1'b1);
            if (CoreHalt !== 1'b1)
                halt_bad++;
            if (DumpDone === 1'b1 && done_at < 0)
                done_at = n;
            @(negedge Clock);
        end
        checks++;
        if (halt_bad != 0) begin
            failures++;
            $display("FAIL stream_halt got low_cycles=%0d exp=0", halt_bad);
        end
        checks++;
        if (done_at != 24) begin
            failures++;
            $display("FAIL stream_done_latency got=%0d exp=24", done_at);
        end
        checks++;
        if (got.size() != 16) begin
            failures++;
            $display("FAIL stream_count got=%0d exp=16", got.size());
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_bytes[i]) begin
                failures++;
                $display("FAIL stream_byte%0d got=%h exp=%h", i,
                         (i < got.size()) ? got[i] : 8'hxx, exp_bytes[i]);
            end
        end
        checks++;
        if (addrs.size() != 4) begin
            failures++;
            $display("FAIL rd_count got=%0d exp=4", addrs.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= addrs.size() || addrs[i] !== exp_addr[i]) begin
                failures++;
                $display("FAIL rd_addr%0d got=%h exp=%h", i,
                         (i < addrs.size()) ? addrs[i] : 32'hx,
                         exp_addr[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int  viol = 0;
        int  bad = 0;
        bit  rdy;
        bit  stall_prev = 1'b0;
        logic [7:0] prev_data = 8'h00;
        do_reset();
        fire_ebreak();
        for (int n = 0; n < 600 && DumpDone !== 1'b1; n++) begin
            if (stall_prev && (TxValid !== 1'b1 || TxData !== prev_data))
                viol++;
            rdy = ($urandom_range(0, 9) < 3);
            sample(rdy);
            stall_prev = TxValid && !rdy;
            prev_data  = TxData;
            @(negedge Clock);
        end
        checks++;
        if (DumpDone !== 1'b1) begin
            failures++;
            $display("FAIL bp_done got=%b exp=1 (cycle budget)", DumpDone);
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL bp_hold got changes=%0d exp=0", viol);
        end
        for (int i = 0; i < 16; i++)
            if (i >= got.size() || got[i] !== exp_bytes[i])
                bad++;
        checks++;
        if (got.size() != 16 || bad != 0) begin
            failures++;
            $display("FAIL bp_bytes got n=%0d wrong=%0d exp n=16 wrong=0",
                     got.size(), bad);
        end
    endtask

    task automatic test_ebreak_ignored();
        do_reset();
        fire_ebreak();
        for (int n = 0; n < 60; n++) begin
            InstructionQ101H = (n == 3 || n == 35) ? EBREAK : NOP;
            sample(1'b1);
            @(negedge Clock);
        end
        InstructionQ101H = NOP;
        checks++;
        if (got.size() != 16 || addrs.size() != 4) begin
            failures++;
            $display("FAIL reebreak_count got bytes=%0d reads=%0d exp 16/4",
                     got.size(), addrs.size());
        end
        checks++;
        if (DumpDone !== 1'b1 || CoreHalt !== 1'b1 || TxValid !== 1'b0) begin
            failures++;
            $display("FAIL reebreak_done got done=%b halt=%b v=%b exp 1/1/0",
                     DumpDone, CoreHalt, TxValid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fire_ebreak();
        for (int n = 0; n < 10; n++) begin
            sample(1'b1);
            @(negedge Clock);
        end
        checks++;
        if (TxValid !== 1'b1 || TxData !== 8'hCC) begin
            failures++;
            $display("FAIL mid_pre got v=%b d=%h exp 1/cc", TxValid, TxData);
        end
        Rst = 1'b1;
        TxReady = 1'b0;
        @(negedge Clock);
        checks++;
        if ({CoreHalt, DumpRdEn, TxValid, DumpBusy, DumpDone} !== 5'b0 ||
            DumpRdAddr !== 32'h0 || TxData !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset got h=%b en=%b v=%b b=%b dn=%b a=%h d=%h exp all 0",
                     CoreHalt, DumpRdEn, TxValid, DumpBusy, DumpDone,
                     DumpRdAddr, TxData);
        end
        Rst = 1'b0;
        @(negedge Clock);
        checks++;
        if (CoreHalt !== 1'b0 || DumpBusy !== 1'b0) begin
            failures++;
            $display("FAIL mid_idle got halt=%b busy=%b exp 0/0",
                     CoreHalt, DumpBusy);
        end
        fire_ebreak();
        checks++;
        if (DumpRdEn !== 1'b1 || DumpRdAddr !== 32'h0000_1000) begin
            failures++;
            $display("FAIL restart_addr got en=%b addr=%h exp 1/00001000",
                     DumpRdEn, DumpRdAddr);
        end
        TxReady = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if (TxValid !== 1'b1 || TxData !== 8'h11) begin
            failures++;
            $display("FAIL restart_byte got v=%b d=%h exp 1/11",
                     TxValid, TxData);
        end
    endtask

    task automatic test_no_ebreak();
        int bad = 0;
        logic [31:0] ins;
        do_reset();
        for (int n = 0; n < 1000; n++) begin
            ins = $urandom;
            InstructionQ101H = (ins == EBREAK) ? NOP : ins;
            TxReady = $urandom_range(0, 1);
            if (CoreHalt !== 1'b0 || TxValid !== 1'b0 || DumpRdEn !== 1'b0)
                bad++;
            @(negedge Clock);
        end
        InstructionQ101H = NOP;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL no_ebreak got active_cycles=%0d exp=0", bad);
        end
    endtask

    initial begin
        mem[0] = 32'h1122_3344;
        mem[1] = 32'hAABB_CCDD;
        mem[2] = 32'h0000_0000;
        mem[3] = 32'hFFFF_FFFF;
        for (int w = 0; w < 4; w++) begin
            exp_addr[w] = 32'h0000_1000 + 32'(4 * w);
            for (int b = 0; b < 4; b++)
                exp_bytes[4*w+b] = mem[w][31-8*b -: 8];
        end
        test_reset();
        test_stream();
        test_backpressure();
        test_ebreak_ignored();
        test_reset_mid();
        test_no_ebreak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
